// File: rtl/taint_tracker_if.sv
// taint_tracker_if
//   Bundles the beat handshake, the control inputs and the taint status
//   outputs of taint_tracker so a single interface instance wires the block.
//
//   Signals
//     in_valid / in_ready / in_data   input beat channel
//     mode, taint_clr                 per-beat mode select, clear pulse
//     out_valid / out_ready           output beat channel
//     out_data, out_mask              processed beat, per-lane input MSBs
//     sticky, taint_cnt               sticky taint flag, tainted-beat counter
//
//   Handshake: a beat moves on a channel in any cycle where valid && ready
//   are both high at the rising clock edge. A producer that has raised valid
//   keeps the beat stable until it has moved.
//
//   Modports
//     master  the environment: drives beats in, drains beats out
//     slave   the tracker itself
interface taint_tracker_if #(
  parameter int LANES  = 2,
  parameter int LANE_W = 32,
  parameter int CNT_W  = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*LANE_W-1:0]   in_data;
  logic [1:0]                mode;
  logic                      taint_clr;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*LANE_W-1:0]   out_data;
  logic [LANES-1:0]          out_mask;
  logic                      sticky;
  logic [CNT_W-1:0]          taint_cnt;

  modport master (
    output in_valid, in_data, mode, taint_clr, out_ready,
    input  in_ready, out_valid, out_data, out_mask, sticky, taint_cnt
  );

  modport slave (
    input  in_valid, in_data, mode, taint_clr, out_ready,
    output in_ready, out_valid, out_data, out_mask, sticky, taint_cnt
  );
endinterface

// File: rtl/taint_tracker.sv
// taint_tracker
//   Single-stage registered pipeline that marks data lanes as tainted. Each
//   lane's MSB is its taint bit. Depending on mode, a beat carrying any taint
//   (or, in sticky mode, any beat after a taint was seen) is forwarded with
//   every lane's MSB forced to 1. A saturating counter tracks accepted tainted
//   beats.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    taint_tracker_if.slave (beat channels, mode, clear, status)
//
//   mode: 00 pass, 01 broadcast, 10 sticky broadcast, 11 treated as 01.
module taint_tracker #(
  parameter int LANES  = 2,
  parameter int LANE_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  taint_tracker_if.slave bus
);

  localparam int W = LANES * LANE_W;

  logic [W-1:0]      r_out_data;
  logic [LANES-1:0]  r_out_mask;
  logic              r_out_valid;
  logic              r_sticky;
  logic [CNT_W-1:0]  r_cnt;

  logic [LANES-1:0]  w_mask;
  logic [W-1:0]      w_forced;
  logic              w_any_taint;
  logic              w_sticky_eff;
  logic              w_force;
  logic              w_in_fire;
  logic              w_taint_fire;
  logic [W-1:0]      w_next_data;

  // Gather lane MSBs and build the all-MSBs-set version of the beat.
  always_comb begin
    w_mask   = '0;
    w_forced = bus.in_data;
    for (int k = 0; k < LANES; k++) begin
      w_mask[k]                       = bus.in_data[k*LANE_W + LANE_W - 1];
      w_forced[k*LANE_W + LANE_W - 1] = 1'b1;
    end
  end

  assign w_any_taint = |w_mask;

  // A clear arriving with a beat already applies to that beat.
  assign w_sticky_eff = r_sticky && !bus.taint_clr;

  always_comb begin
    w_force = 1'b0;
    case (bus.mode)
      2'b00:   w_force = 1'b0;
      2'b10:   w_force = w_any_taint || w_sticky_eff;
      default: w_force = w_any_taint;  // 01 and reserved 11
    endcase
  end

  assign w_next_data  = w_force ? w_forced : bus.in_data;

  // Output slot is free when empty or being drained this cycle.
  assign bus.in_ready = !r_out_valid || bus.out_ready;
  assign w_in_fire    = bus.in_valid && bus.in_ready;
  assign w_taint_fire = w_in_fire && w_any_taint;

  // Output register: loads on accept, empties when drained without refill,
  // otherwise holds the beat stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_mask  <= '0;
    end else if (w_in_fire) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_next_data;
      r_out_mask  <= w_mask;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky flag: a tainted sticky-mode accept wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_taint_fire && (bus.mode == 2'b10)) begin
      r_sticky <= 1'b1;
    end else if (bus.taint_clr) begin
      r_sticky <= 1'b0;
    end
  end

  // Saturating count of accepted beats that carry their own taint.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (bus.taint_clr) begin
      r_cnt <= w_taint_fire ? CNT_W'(1) : '0;
    end else if (w_taint_fire && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_mask  = r_out_mask;
  assign bus.sticky    = r_sticky;
  assign bus.taint_cnt = r_cnt;

endmodule

// File: tb/tb_taint_tracker.sv
module tb_taint_tracker;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  logic [63:0] exp_q[$];

  taint_tracker_if #(.LANES(2), .LANE_W(32), .CNT_W(16)) bus ();
  taint_tracker_if #(.LANES(2), .LANE_W(32), .CNT_W(4))  bus4 ();

  taint_tracker #(.LANES(2), .LANE_W(32), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  taint_tracker #(.LANES(2), .LANE_W(32), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Drive at the falling edge, let one rising edge pass, return at the
  // following falling edge with the beat withdrawn.
  task automatic send(input logic [63:0] data, input logic [1:0] mode, input logic clr);
    bus.in_valid  = 1'b1;
    bus.in_data   = data;
    bus.mode      = mode;
    bus.taint_clr = clr;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.taint_clr = 1'b0;
  endtask

  task automatic send4(input logic [63:0] data, input logic [1:0] mode, input logic clr);
    bus4.in_valid  = 1'b1;
    bus4.in_data   = data;
    bus4.mode      = mode;
    bus4.taint_clr = clr;
    bus4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.in_valid  = 1'b0;
    bus4.taint_clr = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.in_valid  = 1'b0;
    bus.taint_clr = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;

    bus.in_valid   = 1'b0; bus.in_data  = '0; bus.mode  = 2'b00;
    bus.taint_clr  = 1'b0; bus.out_ready = 1'b1;
    bus4.in_valid  = 1'b0; bus4.in_data = '0; bus4.mode = 2'b00;
    bus4.taint_clr = 1'b0; bus4.out_ready = 1'b1;

    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_data",  bus.out_data,       64'd0);
    check("rst_out_mask",  64'(bus.out_mask),  64'd0);
    check("rst_sticky",    64'(bus.sticky),    64'd0);
    check("rst_cnt",       64'(bus.taint_cnt), 64'd0);

    // Beat offered while in reset must not be captured.
    @(negedge clk);
    send(64'h80000000_80000000, 2'b01, 1'b0);
    check("rst_no_capture_valid", 64'(bus.out_valid), 64'd0);
    check("rst_no_capture_cnt",   64'(bus.taint_cnt), 64'd0);
    rst_n = 1'b1;
    idle_cycle();

    // Broadcast mode, tainted upper lane.
    send(64'h80000000_00000005, 2'b01, 1'b0);
    check("bc_taint_data",  bus.out_data,       64'h80000000_80000005);
    check("bc_taint_mask",  64'(bus.out_mask),  64'd2);
    check("bc_taint_cnt",   64'(bus.taint_cnt), 64'd1);
    check("bc_taint_valid", 64'(bus.out_valid), 64'd1);

    // Broadcast mode, clean beat passes untouched.
    send(64'h12345678_7FFFFFFF, 2'b01, 1'b0);
    check("bc_clean_data", bus.out_data,       64'h12345678_7FFFFFFF);
    check("bc_clean_mask", 64'(bus.out_mask),  64'd0);
    check("bc_clean_cnt",  64'(bus.taint_cnt), 64'd1);

    // Pass mode never forces but still counts and masks.
    send(64'h80000000_00000001, 2'b00, 1'b0);
    check("pass_data",   bus.out_data,       64'h80000000_00000001);
    check("pass_mask",   64'(bus.out_mask),  64'd2);
    check("pass_cnt",    64'(bus.taint_cnt), 64'd2);
    check("pass_sticky", 64'(bus.sticky),    64'd0);

    // Sticky mode: tainted beat sets the flag and forces all lanes.
    send(64'h00000000_80000000, 2'b10, 1'b0);
    check("stk_taint_data",   bus.out_data,       64'h80000000_80000000);
    check("stk_taint_mask",   64'(bus.out_mask),  64'd1);
    check("stk_taint_sticky", 64'(bus.sticky),    64'd1);
    check("stk_taint_cnt",    64'(bus.taint_cnt), 64'd3);

    // Clean beat forced by sticky flag, not counted.
    send(64'h00000001_00000002, 2'b10, 1'b0);
    check("stk_clean_data",   bus.out_data,       64'h80000001_80000002);
    check("stk_clean_mask",   64'(bus.out_mask),  64'd0);
    check("stk_clean_sticky", 64'(bus.sticky),    64'd1);
    check("stk_clean_cnt",    64'(bus.taint_cnt), 64'd3);

    // Sticky flag ignored outside mode 10 but persists.
    send(64'h00000001_00000002, 2'b01, 1'b0);
    check("stk_other_mode_data",   bus.out_data,    64'h00000001_00000002);
    check("stk_other_mode_sticky", 64'(bus.sticky), 64'd1);

    // Clear arriving with a clean sticky-mode beat applies to that beat.
    send(64'h00000001_00000002, 2'b10, 1'b1);
    check("clr_same_data",   bus.out_data,       64'h00000001_00000002);
    check("clr_same_sticky", 64'(bus.sticky),    64'd0);
    check("clr_same_cnt",    64'(bus.taint_cnt), 64'd0);

    // Set wins over clear; counter becomes 1.
    send(64'h80000000_00000000, 2'b10, 1'b1);
    check("set_wins_sticky", 64'(bus.sticky),    64'd1);
    check("set_wins_cnt",    64'(bus.taint_cnt), 64'd1);
    check("set_wins_data",   bus.out_data,       64'h80000000_80000000);

    // Clear pulse alone: status clears, output register untouched by it.
    bus.taint_clr = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.taint_clr = 1'b0;
    check("clr_only_sticky", 64'(bus.sticky),    64'd0);
    check("clr_only_cnt",    64'(bus.taint_cnt), 64'd0);
    check("clr_only_valid",  64'(bus.out_valid), 64'd0);
    check("clr_only_data",   bus.out_data,       64'h80000000_80000000);

    // Reserved mode behaves as broadcast.
    send(64'h00000000_80000000, 2'b11, 1'b0);
    check("rsv_data", bus.out_data,       64'h80000000_80000000);
    check("rsv_cnt",  64'(bus.taint_cnt), 64'd1);
    idle_cycle();

    // Backpressure: hold A for 3 cycles while B waits.
    exp_q.push_back(64'h0000000A_0000000B);
    exp_q.push_back(64'h000000C0_000000D0);
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'h0000000A_0000000B;
    bus.mode      = 2'b00;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_data = 64'h000000C0_000000D0;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready",  64'(bus.in_ready),  64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_hold_data", bus.out_data,       64'h0000000A_0000000B);
      @(posedge clk);
      @(negedge clk);
    end
    check("bp_first_out", bus.out_data, exp_q.pop_front());
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_second_valid", 64'(bus.out_valid), 64'd1);
    check("bp_second_out",   bus.out_data,       exp_q.pop_front());
    check("bp_queue_empty",  64'(exp_q.size()),  64'd0);
    @(posedge clk);
    @(negedge clk);
    check("bp_drained", 64'(bus.out_valid), 64'd0);

    // Saturation on the 4-bit counter instance.
    check("sat_start", 64'(bus4.taint_cnt), 64'd0);
    for (int i = 0; i < 20; i++) begin
      send4(64'h00000000_80000000 + 64'(i), 2'b01, 1'b0);
      if (i == 14) check("sat_at_15", 64'(bus4.taint_cnt), 64'hF);
    end
    check("sat_held", 64'(bus4.taint_cnt), 64'hF);
    send4(64'h80000000_00000000, 2'b01, 1'b1);
    check("sat_clr_taint", 64'(bus4.taint_cnt), 64'd1);

    // Asynchronous reset mid-cycle with live state.
    send(64'h00000000_00000000, 2'b00, 1'b1);
    for (int i = 0; i < 7; i++) send(64'h80000000_00000000, 2'b10, 1'b0);
    check("pre_rst_valid",  64'(bus.out_valid), 64'd1);
    check("pre_rst_sticky", 64'(bus.sticky),    64'd1);
    check("pre_rst_cnt",    64'(bus.taint_cnt), 64'd7);
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid",  64'(bus.out_valid), 64'd0);
    check("async_rst_sticky", 64'(bus.sticky),    64'd0);
    check("async_rst_cnt",    64'(bus.taint_cnt), 64'd0);
    check("async_rst_data",   bus.out_data,       64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First beat after reset behaves normally.
    send(64'h00000003_80000004, 2'b01, 1'b0);
    check("post_rst_data", bus.out_data,       64'h80000003_80000004);
    check("post_rst_cnt",  64'(bus.taint_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
